// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned OFF_W  = 5;
  localparam int unsigned MEM_AW = 27;
  localparam int unsigned WSEL_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_e;

  function automatic logic [WSEL_W-1:0] word_of(input logic [31:0] addr);
    return addr[4:2];
  endfunction

  function automatic logic [MEM_AW-1:0] line_of(input logic [31:0] addr);
    return addr[31:OFF_W];
  endfunction

  // Index and tag are returned zero-extended; callers size them to their IDX_W/TAG_W.
  function automatic logic [31:0] idx_of(input logic [31:0] addr, input int unsigned idx_w);
    return (addr >> OFF_W) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] addr, input int unsigned idx_w);
    return addr >> (OFF_W + idx_w);
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/dirty/tag/data arrays for the data cache: combinational read port,
// synchronous word write and whole-line fill, async clear of valid/dirty.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned TAG_W     = 22
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_line_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [WSEL_W-1:0] wr_word_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              fill_en_i,
  input  logic [IDX_W-1:0]  fill_idx_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [LINE_W-1:0] fill_line_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fill_idx_i] <= 1'b1;
      dirty_q[fill_idx_i] <= 1'b0;
    end else if (wr_en_i) begin
      dirty_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid gates every use of them.
  always_ff @(posedge clk_i) begin
    if (fill_en_i) begin
      tag_q[fill_idx_i]  <= fill_tag_i;
      data_q[fill_idx_i] <= fill_line_i;
    end else if (wr_en_i) begin
      data_q[wr_idx_i][int'(wr_word_i)*WORD_W +: WORD_W] <= wr_data_i;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller:
// single-cycle hits, dirty-victim writeback then line refill on a miss.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned LINE_W    = 256,
  parameter int unsigned MEM_AW    = 27
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_ren_o,
  output logic              mem_wen_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 32 - OFF_W - IDX_W;

  state_e state_q, state_d;
  logic   ren_q, wen_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] word;
  logic              l_valid, l_dirty, hit;
  logic [TAG_W-1:0]  l_tag;
  logic [LINE_W-1:0] l_line;
  logic              wr_en, fill_en, stall;

  assign idx  = IDX_W'(idx_of(cpu_addr_i, IDX_W));
  assign tag  = TAG_W'(tag_of(cpu_addr_i, IDX_W));
  assign word = word_of(cpu_addr_i);
  assign hit  = l_valid && (l_tag == tag);

  dcache_line_store #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_store (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rd_idx_i    (idx),
    .rd_valid_o  (l_valid),
    .rd_dirty_o  (l_dirty),
    .rd_tag_o    (l_tag),
    .rd_line_o   (l_line),
    .wr_en_i     (wr_en),
    .wr_idx_i    (idx),
    .wr_word_i   (word),
    .wr_data_i   (cpu_wdata_i),
    .fill_en_i   (fill_en),
    .fill_idx_i  (idx),
    .fill_tag_i  (tag),
    .fill_line_i (mem_rdata_i)
  );

  always_comb begin
    state_d     = state_q;
    stall       = 1'b1;
    wr_en       = 1'b0;
    fill_en     = 1'b0;
    cpu_rdata_o = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (state_q)
      IDLE: begin
        stall = cpu_req_i && !hit;
        if (hit) begin
          cpu_rdata_o = l_line[int'(word)*WORD_W +: WORD_W];
        end
        if (cpu_req_i) begin
          if (hit) begin
            wr_en = cpu_we_i;
          end else begin
            state_d = (l_valid && l_dirty) ? WRITEBACK : REFILL;
          end
        end
      end
      WRITEBACK: begin
        mem_addr_o  = MEM_AW'({l_tag, idx});
        mem_wdata_o = l_line;
        if (mem_ready_i) begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        mem_addr_o = MEM_AW'(line_of(cpu_addr_i));
        if (mem_ready_i) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they rise in the same cycle the
  // FSM enters WRITEBACK/REFILL, keeping the miss latency at one cycle per state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ren_q   <= (state_d == REFILL);
      wen_q   <= (state_d == WRITEBACK);
    end
  end

  assign mem_ren_o   = ren_q;
  assign mem_wen_o   = wen_q;
  assign cpu_stall_o = stall || !rst_ni;

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller against a 512-line memory model.
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         mem_ren, mem_wen, mem_ready;
  logic [26:0]  mem_addr;
  logic [255:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dcache_controller #(
    .NUM_LINES (32),
    .LINE_W    (256),
    .MEM_AW    (27)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_rdata_o (cpu_rdata),
    .cpu_stall_o (cpu_stall),
    .mem_ren_o   (mem_ren),
    .mem_wen_o   (mem_wen),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ready_i (mem_ready)
  );

  // Memory model: ready rises once the strobe has been high for ready_delay cycles.
  logic [255:0] mem [512];
  int ready_delay = 0;
  int rcnt = 0;

  assign mem_ready = (mem_ren || mem_wen) && (rcnt >= ready_delay);
  assign mem_rdata = mem[mem_addr[8:0]];

  always @(posedge clk) begin
    if ((mem_ren || mem_wen) && !mem_ready) rcnt <= rcnt + 1;
    else rcnt <= 0;
    if (mem_wen && mem_ready) mem[mem_addr[8:0]] <= mem_wdata;
  end

  typedef struct {
    string       name;
    bit          chk;
    logic [31:0] rdata;
    int          stalls;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  int          scnt = 0;
  int          ren_cyc = 0, wen_cyc = 0, ren_addr_chg = 0, both = 0;
  logic [26:0] ren_addr = '0, wen_addr = '0;
  logic [31:0] wen_word1 = '0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: counts stall cycles of the current access and pops an expectation on completion.
  always @(negedge clk) begin
    if (!rst_n || !cpu_req) begin
      scnt = 0;
    end else if (cpu_stall) begin
      scnt++;
    end else begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: got addr %h expected no access", cpu_addr);
      end else begin
        mon_e = sbq.pop_front();
        check({mon_e.name, "_stall"}, 256'(scnt), 256'(mon_e.stalls));
        if (mon_e.chk) check({mon_e.name, "_rdata"}, 256'(cpu_rdata), 256'(mon_e.rdata));
      end
      scnt = 0;
    end
    if (mem_ren) begin
      if (ren_cyc > 0 && mem_addr != ren_addr) ren_addr_chg++;
      ren_cyc++;
      ren_addr = mem_addr;
    end
    if (mem_wen) begin
      wen_cyc++;
      wen_addr  = mem_addr;
      wen_word1 = mem_wdata[63:32];
    end
    if (mem_ren && mem_wen) both++;
  end

  task automatic clr();
    ren_cyc = 0; wen_cyc = 0; ren_addr_chg = 0;
  endtask

  task automatic access(input string name, input logic [31:0] addr, input bit we,
                        input logic [31:0] wd, input bit chk, input logic [31:0] exp_rd,
                        input int exp_st);
    int n;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    sbq.push_back('{name, chk, exp_rd, exp_st});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cpu_stall && n < 100);
    if (cpu_stall) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got stall after %0d cycles expected completion", name, n);
      sbq.delete();
      cpu_req = 1'b0;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int l = 0; l < 512; l++)
      for (int w = 0; w < 8; w++)
        mem[l][w*32 +: 32] = {l[23:0], w[7:0]};

    #3;
    check("rst_ren", 256'(mem_ren), 256'(0));
    check("rst_wen", 256'(mem_wen), 256'(0));
    check("rst_addr", 256'(mem_addr), 256'(0));
    check("rst_wdata", mem_wdata, 256'(0));
    check("rst_rdata", 256'(cpu_rdata), 256'(0));
    check("rst_stall", 256'(cpu_stall), 256'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // T1 cold load
    clr();
    access("t1_load", 32'h0000_0024, 1'b0, '0, 1'b1, 32'h0000_0101, 2);
    idle();
    check("t1_ren_cycles", 256'(ren_cyc), 256'(1));
    check("t1_ren_addr", 256'(ren_addr), 256'(27'h000_0001));
    check("t1_wen_cycles", 256'(wen_cyc), 256'(0));

    // T2 store hit, load hit
    clr();
    access("t2_store", 32'h0000_0024, 1'b1, 32'hDEAD_BEEF, 1'b0, '0, 0);
    access("t2_load", 32'h0000_0024, 1'b0, '0, 1'b1, 32'hDEAD_BEEF, 0);
    idle();
    check("t2_ren_cycles", 256'(ren_cyc), 256'(0));
    check("t2_wen_cycles", 256'(wen_cyc), 256'(0));

    // T3 conflict miss with dirty victim
    clr();
    access("t3_load", 32'h0000_0424, 1'b0, '0, 1'b1, 32'h0000_2101, 3);
    idle();
    check("t3_wen_cycles", 256'(wen_cyc), 256'(1));
    check("t3_wen_addr", 256'(wen_addr), 256'(27'h000_0001));
    check("t3_wen_word1", 256'(wen_word1), 256'(32'hDEAD_BEEF));
    check("t3_ren_cycles", 256'(ren_cyc), 256'(1));
    check("t3_ren_addr", 256'(ren_addr), 256'(27'h000_0021));
    check("t3_both", 256'(both), 256'(0));

    // T4 slow memory on a clean miss
    clr();
    ready_delay = 9;
    access("t4_load", 32'h0000_0080, 1'b0, '0, 1'b1, 32'h0000_0400, 11);
    idle();
    ready_delay = 0;
    check("t4_ren_cycles", 256'(ren_cyc), 256'(10));
    check("t4_ren_addr_changes", 256'(ren_addr_chg), 256'(0));
    check("t4_ren_addr", 256'(ren_addr), 256'(27'h000_0004));

    // T5 reset during writeback
    access("t5_store", 32'h0000_00A0, 1'b1, 32'h1234_5678, 1'b0, '0, 2);
    idle();
    clr();
    ready_delay = 5;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_04A0;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!mem_wen && n < 20);
      check("t5_wen_seen", 256'(mem_wen), 256'(1));
    end
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_wen", 256'(mem_wen), 256'(0));
    check("t5_rst_ren", 256'(mem_ren), 256'(0));
    check("t5_rst_stall", 256'(cpu_stall), 256'(1));
    @(posedge clk); #1;
    cpu_req = 1'b0;
    ready_delay = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    clr();
    access("t5_reload", 32'h0000_00A0, 1'b0, '0, 1'b1, 32'h0000_0500, 2);
    idle();
    check("t5_wen_cycles", 256'(wen_cyc), 256'(0));
    check("t5_ren_cycles", 256'(ren_cyc), 256'(1));

    // T6 fill line 0x21, then eight back-to-back hits
    access("t6_fill", 32'h0000_0420, 1'b0, '0, 1'b1, 32'h0000_2100, 2);
    clr();
    for (int w = 0; w < 8; w++)
      access($sformatf("t6_w%0d", w), 32'h0000_0420 + 32'(4*w), 1'b0, '0, 1'b1,
             32'h0000_2100 + 32'(w), 0);
    idle();
    check("t6_ren_cycles", 256'(ren_cyc), 256'(0));

    // Address wrap: top word of the address space
    clr();
    access("wrap_load", 32'hFFFF_FFFC, 1'b0, '0, 1'b1, 32'h0001_FF07, 2);
    idle();
    check("wrap_ren_addr", 256'(ren_addr), 256'(27'h7FF_FFFF));

    repeat (2) @(posedge clk);
    check("never_both_strobes", 256'(both), 256'(0));
    check("scoreboard_empty", 256'(sbq.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
